// File: rtl/pool_stream.sv
// Streaming 2-D pooling over a raster-order pixel stream, per-column accumulator bank.
// Optional macro POOL_AVG_EN adds the average-pooling datapath selected by mode.
module pool_stream #(
    parameter int NUM_FEATURES = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int IN_HEIGHT    = 25,
    parameter int IN_WIDTH     = 25,
    parameter int POOL_SIZE    = 2,
    localparam int OUT_HEIGHT  = IN_HEIGHT / POOL_SIZE,
    localparam int OUT_WIDTH   = IN_WIDTH / POOL_SIZE,
    localparam int OROW_W      = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1,
    localparam int OCOL_W      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      mode,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]   in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]   out_data,
    output logic [OROW_W-1:0]                         out_row,
    output logic [OCOL_W-1:0]                         out_col,
    output logic                                      busy,
    output logic                                      done
);

    localparam int LOG2P = $clog2(POOL_SIZE);
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
`ifdef POOL_AVG_EN
    localparam int SH    = 2 * LOG2P;
    localparam int ACC_W = DATA_WIDTH + SH;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                                 state_q, state_d;
    logic [ROW_W-1:0]                       row_q, row_d;
    logic [COL_W-1:0]                       col_q, col_d;
    logic                                   out_valid_q;
    logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] out_data_q;
    logic [OROW_W-1:0]                      out_row_q;
    logic [OCOL_W-1:0]                      out_col_q;
    logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] res_w;

    logic in_fire, out_fire, last_pix, in_win, win_first, win_last;
    logic [OROW_W-1:0] orow;
    logic [OCOL_W-1:0] ocol;

`ifdef POOL_AVG_EN
    logic mode_q, mode_d;
`else
    logic mode_unused;
    assign mode_unused = mode;
`endif

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign last_pix  = (row_q == ROW_W'(IN_HEIGHT - 1)) && (col_q == COL_W'(IN_WIDTH - 1));
    assign in_win    = (int'(row_q) < OUT_HEIGHT * POOL_SIZE) && (int'(col_q) < OUT_WIDTH * POOL_SIZE);
    assign win_first = (row_q[LOG2P-1:0] == '0) && (col_q[LOG2P-1:0] == '0);
    assign win_last  = (&row_q[LOG2P-1:0]) && (&col_q[LOG2P-1:0]);
    assign orow      = OROW_W'(row_q >> LOG2P);
    assign ocol      = OCOL_W'(col_q >> LOG2P);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done    = 1'b0;
`ifdef POOL_AVG_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
`ifdef POOL_AVG_EN
                    mode_d  = mode;
`endif
                end
            end
            RUN: begin
                if (in_fire) begin
                    if (col_q == COL_W'(IN_WIDTH - 1)) begin
                        col_d = '0;
                        row_d = last_pix ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Frame ends once the final pooled pixel has left the output register
                if (!out_valid_q || out_fire) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FEATURES; gi++) begin : g_feat
            logic signed [ACC_W-1:0] acc_q [OUT_WIDTH];
            logic signed [ACC_W-1:0] samp;
            logic signed [ACC_W-1:0] comb_v;

            assign samp = ACC_W'($signed(in_data[gi]));
`ifdef POOL_AVG_EN
            assign comb_v    = mode_q ? (acc_q[ocol] + samp)
                                      : ((samp > acc_q[ocol]) ? samp : acc_q[ocol]);
            assign res_w[gi] = mode_q ? DATA_WIDTH'(comb_v >>> SH) : DATA_WIDTH'(comb_v);
`else
            assign comb_v    = (samp > acc_q[ocol]) ? samp : acc_q[ocol];
            assign res_w[gi] = DATA_WIDTH'(comb_v);
`endif

            always_ff @(posedge clk) begin
                if (in_fire && in_win)
                    acc_q[ocol] <= win_first ? samp : comb_v;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
`ifdef POOL_AVG_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
`ifdef POOL_AVG_EN
            mode_q  <= mode_d;
`endif
            // in_ready guarantees the register is empty or draining when a window completes
            if (in_fire && in_win && win_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_w;
                out_row_q   <= orow;
                out_col_q   <= ocol;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Randomized bench for pool_stream on a 5x5 frame with 2x2 pooling; reference model
// computes each window's max/floor-average straight from the stored frame.
module tb_pool_stream;

    localparam int NF = 3;
    localparam int DW = 8;
    localparam int IH = 5;
    localparam int IW = 5;
    localparam int P  = 2;
    localparam int OH = IH / P;
    localparam int OW = IW / P;
    localparam int OROW_W = (OH > 1) ? $clog2(OH) : 1;
    localparam int OCOL_W = (OW > 1) ? $clog2(OW) : 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [NF-1:0][DW-1:0] in_data = '0;
    logic in_ready, out_valid, busy, done;
    logic [NF-1:0][DW-1:0] out_data;
    logic [OROW_W-1:0] out_row;
    logic [OCOL_W-1:0] out_col;

    int vectors = 0;
    int miscompares = 0;
    int pix [IH][IW][NF];

    pool_stream #(
        .NUM_FEATURES(NF), .DATA_WIDTH(DW), .IN_HEIGHT(IH), .IN_WIDTH(IW), .POOL_SIZE(P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int ref_pool(input int r, input int c, input int f, input bit avg);
        int m, s, q, v;
        m = pix[P*r][P*c][f];
        s = 0;
        for (int dr = 0; dr < P; dr++)
            for (int dc = 0; dc < P; dc++) begin
                v = pix[P*r+dr][P*c+dc][f];
                if (v > m) m = v;
                s += v;
            end
        if (!avg) return m;
        q = s / (P*P);
        if (s < 0 && q * (P*P) != s) q = q - 1;
        return q;
    endfunction

    function automatic logic [NF*DW-1:0] pack_pix(input int r, input int c);
        logic [NF-1:0][DW-1:0] v;
        for (int f = 0; f < NF; f++) v[f] = DW'(pix[r][c][f]);
        return v;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                for (int f = 0; f < NF; f++)
                    pix[r][c][f] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_col"}, out_col, 0);
    endtask

    task automatic run_frame(input bit md, input int vld_pct, input int rdy_pct, input bit stall);
        bit avg;
        int exp_r[$];
        int exp_c[$];
        logic [NF*DW-1:0] exp_d[$];
        logic [NF-1:0][DW-1:0] ev;
        int idx, got, dones, stall_left;
        bit stalled;
`ifdef POOL_AVG_EN
        avg = md;
`else
        avg = 1'b0;
`endif
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                for (int f = 0; f < NF; f++) ev[f] = DW'(ref_pool(r, c, f, avg));
                exp_r.push_back(r);
                exp_c.push_back(c);
                exp_d.push_back(ev);
            end
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        idx = 0; got = 0; dones = 0; stall_left = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mode     = 1'($urandom);
            start    = ($urandom_range(9) == 0);
            in_valid = (idx < IH*IW) && ($urandom_range(99) < vld_pct);
            if (in_valid) in_data = pack_pix(idx / IW, idx % IW);
            else          in_data = (NF*DW)'($urandom);
            stalled = 1'b0;
            if (stall && stall_left < 0 && out_valid) stall_left = 10;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            #1;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_data", out_data, exp_d[0]);
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    check("extra_output", 1, 0);
                end else begin
                    check($sformatf("out%0d_data", got), out_data, exp_d[0]);
                    check($sformatf("out%0d_row", got), out_row, exp_r[0]);
                    check($sformatf("out%0d_col", got), out_col, exp_c[0]);
                    void'(exp_d.pop_front());
                    void'(exp_r.pop_front());
                    void'(exp_c.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            if (done) begin
                dones++;
                check("done_outputs", got, OH*OW);
                check("done_inputs", idx, IH*IW);
                break;
            end
        end
        check("frame_done_seen", dones, 1);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("post_frame_busy", busy, 0);
        check("post_frame_done", done, 0);
    endtask

    task automatic mid_frame_reset();
        int idx;
        fill_random();
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = 1'b1;
            in_data  = pack_pix(idx / IW, idx % IW);
            #1;
            if (in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("pre_reset_out_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Feature 0 counts 0..24 in raster order
        fill_random();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) pix[r][c][0] = r*IW + c;
        run_frame(1'b0, 100, 100, 1'b0);

        // All-negative max window, and positive/negative average windows
        fill_random();
        pix[0][0][0] = -8; pix[0][1][0] = -3; pix[1][0][0] = -5; pix[1][1][0] = -7;
        pix[0][2][1] = 1;  pix[0][3][1] = 2;  pix[1][2][1] = 2;  pix[1][3][1] = 2;
        pix[2][0][2] = -1; pix[2][1][2] = -2; pix[3][0][2] = -2; pix[3][1][2] = -2;
        run_frame(1'b0, 100, 100, 1'b0);
        run_frame(1'b1, 100, 100, 1'b0);

        fill_random();
        run_frame(1'($urandom), 80, 100, 1'b1);

        mid_frame_reset();
        fill_random();
        run_frame(1'b0, 90, 90, 1'b0);

        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_frame(1'($urandom), $urandom_range(30, 100), $urandom_range(30, 100), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
